// File: rtl/axi_aw_w_rr_arbiter.sv
// Round-robin arbiter sharing one slave AW+W write port between NUM masters.
// A grant is held from AW acceptance through the WLAST beat; only handshakes pass through here.
module axi_aw_w_rr_arbiter #(
  parameter int NUM   = 2,
  parameter int IDX_W = (NUM > 1) ? $clog2(NUM) : 1
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [NUM-1:0]   m_awvalid,
  output logic [NUM-1:0]   m_awready,
  input  logic [NUM-1:0]   m_wvalid,
  output logic [NUM-1:0]   m_wready,
  output logic             s_awvalid,
  input  logic             s_awready,
  output logic             s_wvalid,
  input  logic             s_wready,
  input  logic             s_wlast,
  output logic [NUM-1:0]   grant_oh,
  output logic [IDX_W-1:0] grant_idx,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  localparam logic [IDX_W:0] NUM_L = (IDX_W + 1)'(NUM);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic [NUM-1:0]   grant_oh_q, grant_oh_d;

  logic [2*NUM-1:0] req_dbl;
  logic [NUM-1:0]   req_rot;
  logic             found;
  logic [IDX_W-1:0] offset;
  logic [IDX_W:0]   pick_sum;
  logic [IDX_W:0]   next_sum;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] next_ptr;

  // Rotate requests so rr_ptr sits at bit 0, then the lowest set bit is the winner.
  always_comb begin
    req_dbl = {m_awvalid, m_awvalid} >> rr_ptr_q;
    req_rot = req_dbl[NUM-1:0];
    found   = 1'b0;
    offset  = '0;
    for (int i = NUM - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        found  = 1'b1;
        offset = IDX_W'(i);
      end
    end
    pick_sum = {1'b0, rr_ptr_q} + {1'b0, offset};
    if (pick_sum >= NUM_L) pick_sum = pick_sum - NUM_L;
    pick_idx = pick_sum[IDX_W-1:0];
    next_sum = {1'b0, grant_idx_q} + (IDX_W + 1)'(1);
    if (next_sum >= NUM_L) next_sum = next_sum - NUM_L;
    next_ptr = next_sum[IDX_W-1:0];
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_oh_d  = grant_oh_q;
    grant_idx_d = grant_idx_q;
    s_awvalid   = 1'b0;
    s_wvalid    = 1'b0;
    m_awready   = '0;
    m_wready    = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_idx_d = pick_idx;
          grant_oh_d  = NUM'(1) << pick_idx;
          state_d     = ADDR;
        end
      end
      ADDR: begin
        s_awvalid = |(m_awvalid & grant_oh_q);
        m_awready = grant_oh_q & {NUM{s_awready}};
        if (s_awvalid && s_awready) state_d = DATA;
      end
      DATA: begin
        // W is only opened after the AW handshake, so an early W beat waits here.
        s_wvalid = |(m_wvalid & grant_oh_q);
        m_wready = grant_oh_q & {NUM{s_wready}};
        if (s_wvalid && s_wready && s_wlast) begin
          rr_ptr_d    = next_ptr;
          grant_oh_d  = '0;
          grant_idx_d = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_oh_q  <= '0;
      grant_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_oh_q  <= grant_oh_d;
      grant_idx_q <= grant_idx_d;
    end
  end

  assign grant_oh  = grant_oh_q;
  assign grant_idx = grant_idx_q;
  assign busy      = (state_q != IDLE);

endmodule
